// File: rtl/mem_stage_if.sv
// mem_stage_if: EX->MEM input, SRAM read data and MEM->WB/forwarding output buses
interface mem_stage_if;
  logic [5:0]   stall;
  logic [151:0] ex_to_mem_bus;
  logic [31:0]  data_sram_rdata;
  logic [135:0] mem_to_wb_bus;
  logic [37:0]  mem_to_rf_bus;
  logic [65:0]  mem_to_hilo_bus;
  logic         mem_is_load;
  modport master (
    output stall, ex_to_mem_bus, data_sram_rdata,
    input  mem_to_wb_bus, mem_to_rf_bus, mem_to_hilo_bus, mem_is_load
  );
  modport slave (
    input  stall, ex_to_mem_bus, data_sram_rdata,
    output mem_to_wb_bus, mem_to_rf_bus, mem_to_hilo_bus, mem_is_load
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline register, load-data capture/alignment and WB/forwarding buses
module mem_stage (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave m
);
  logic [151:0] bus_r;
  logic         fresh;
  logic [31:0]  rdata_hold;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_r      <= '0;
      fresh      <= 1'b0;
      rdata_hold <= '0;
    end else begin
      bus_r <= !m.stall[3] ? m.ex_to_mem_bus : !m.stall[4] ? '0 : bus_r;
      fresh <= !m.stall[3];
      if (fresh) rdata_hold <= m.data_sram_rdata;
    end
  end
  logic [31:0] pc, ex_result, hi_i, lo_i;
  logic        sel_rf_res, rf_we, w_hi_we, w_lo_we;
  logic [4:0]  rf_waddr;
  logic [5:0]  opcode;
  logic [3:0]  sel;
  assign pc         = bus_r[151:120];
  assign sel_rf_res = bus_r[114];
  assign rf_we      = bus_r[113];
  assign rf_waddr   = bus_r[112:108];
  assign ex_result  = bus_r[107:76];
  assign w_hi_we    = bus_r[75];
  assign w_lo_we    = bus_r[74];
  assign hi_i       = bus_r[73:42];
  assign lo_i       = bus_r[41:10];
  assign opcode     = bus_r[9:4];
  assign sel        = bus_r[3:0];
  logic unused_ok;
  assign unused_ok = ^{bus_r[119:115], m.stall[5], m.stall[2:0]};
  logic is_lw, is_lb, is_lbu, is_lh, is_lhu, is_load;
  assign is_lw   = opcode == 6'b100011;
  assign is_lb   = opcode == 6'b100000;
  assign is_lbu  = opcode == 6'b100100;
  assign is_lh   = opcode == 6'b100001;
  assign is_lhu  = opcode == 6'b100101;
  assign is_load = is_lw | is_lb | is_lbu | is_lh | is_lhu;
  // SRAM data is only live on the first cycle in the stage; after that use the captured copy
  logic [31:0] load_word, load_data, rf_wdata;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        byte_ok, half_ok;
  always_comb begin
    load_word = fresh ? m.data_sram_rdata : rdata_hold;
    byte_v    = sel == 4'b0001 ? load_word[7:0]   :
                sel == 4'b0010 ? load_word[15:8]  :
                sel == 4'b0100 ? load_word[23:16] : load_word[31:24];
    byte_ok   = sel == 4'b0001 || sel == 4'b0010 || sel == 4'b0100 || sel == 4'b1000;
    half_v    = sel == 4'b0011 ? load_word[15:0] : load_word[31:16];
    half_ok   = sel == 4'b0011 || sel == 4'b1100;
    load_data = is_lw                          ? load_word :
                (is_lb | is_lbu) && byte_ok    ? {{24{is_lb & byte_v[7]}}, byte_v} :
                (is_lh | is_lhu) && half_ok    ? {{16{is_lh & half_v[15]}}, half_v} : '0;
    rf_wdata  = (sel_rf_res & is_load) ? load_data : ex_result;
  end
  assign m.mem_to_wb_bus   = {pc, rf_we, rf_waddr, rf_wdata, w_hi_we, w_lo_we, hi_i, lo_i};
  assign m.mem_to_rf_bus   = {rf_we, rf_waddr, rf_wdata};
  assign m.mem_to_hilo_bus = {w_hi_we, w_lo_we, hi_i, lo_i};
  assign m.mem_is_load     = is_load;
endmodule
